// File: rtl/focus_pkg.sv
// focus_pkg: shared constants and types for the focus error front end.
//   DIFF_W           width of the signed per-sample focus error
//   OUT_W            width of the signed averaged output
//   SAT_MAX/SAT_MIN  clip limits applied to the averaged output
//   state_t          front-end state (ACCUM / LOST)
package focus_pkg;
  localparam int DIFF_W  = 18;
  localparam int OUT_W   = 16;
  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    LOST  = 1'b1
  } state_t;
endpackage

// File: rtl/focus_median3.sv
// focus_median3: combinational median of three signed DIFF_W values.
//   a, b, c  in  : candidate values
//   m        out : median of a, b, c
// Only compiled when FOCUS_DEGLITCH_EN is defined, since it is only used by
// the deglitch path; otherwise it would be a dangling top-level module.
`ifdef FOCUS_DEGLITCH_EN
module focus_median3
  import focus_pkg::*;
(
  input  logic signed [DIFF_W-1:0] a,
  input  logic signed [DIFF_W-1:0] b,
  input  logic signed [DIFF_W-1:0] c,
  output logic signed [DIFF_W-1:0] m
);
  logic signed [DIFF_W-1:0] lo, hi;

  assign lo = (a < b) ? a : b;
  assign hi = (a < b) ? b : a;
  // Clamp c into [lo, hi]; the clamped value is the median.
  assign m  = (c < lo) ? lo : ((c > hi) ? hi : c);
endmodule
`endif

// File: rtl/focus_error_frontend.sv
// focus_error_frontend: forms (A - B - offset) from two photodiode ADC
// channels, averages it over 2^LOG2_AVG accepted pairs and emits a saturated
// signed 16-bit focus error. Declares signal loss after LOST_CNT consecutive
// pairs whose sum is below min_sum, emitting a single zero output.
//   clk_slow, reset_n          clock, async active-low reset
//   adc_a, adc_b, adc_valid    unsigned sample pair, no backpressure
//   offset                     signed error offset, taken with each pair
//   min_sum                    signal-present threshold on A + B
//   focus_signal, focus_valid  registered average and its one-cycle strobe
//   signal_lost                high while in LOST
//   sat                        last emitted average was clipped
// Optional: FOCUS_DEGLITCH_EN inserts a median-of-3 on the per-sample error.
module focus_error_frontend
  import focus_pkg::*;
#(
  parameter int ADC_W    = 12,
  parameter int LOG2_AVG = 3,
  parameter int LOST_CNT = 4
) (
  input  logic                    clk_slow,
  input  logic                    reset_n,
  input  logic [ADC_W-1:0]        adc_a,
  input  logic [ADC_W-1:0]        adc_b,
  input  logic                    adc_valid,
  input  logic signed [OUT_W-1:0] offset,
  input  logic [ADC_W:0]          min_sum,
  output logic signed [OUT_W-1:0] focus_signal,
  output logic                    focus_valid,
  output logic                    signal_lost,
  output logic                    sat
);
  localparam int ACC_W = DIFF_W + LOG2_AVG;
  // A zero-width counter is illegal; with LOG2_AVG=0 every pair completes.
  localparam int CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam int LC_W  = $clog2(LOST_CNT + 1);

  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'((1 << LOG2_AVG) - 1);
  localparam logic [LC_W-1:0]         LC_LAST  = LC_W'(LOST_CNT - 1);
  localparam logic signed [ACC_W-1:0] LIM_HI   = ACC_W'(SAT_MAX);
  localparam logic signed [ACC_W-1:0] LIM_LO   = ACC_W'(SAT_MIN);

  state_t                   state;
  logic signed [ACC_W-1:0]  acc, acc_next, avg;
  logic [CNT_W-1:0]         cnt;
  logic [LC_W-1:0]          lowcnt;
  logic signed [DIFF_W-1:0] diff_raw, diff_f;
  logic [ADC_W:0]           sum;
  logic                     low, is_last, enter_lost, do_acc, clip_hi, clip_lo;

  // A and B zero-extended, offset sign-extended; 18 bits cannot overflow.
  assign diff_raw = $signed({{(DIFF_W-ADC_W){1'b0}}, adc_a})
                  - $signed({{(DIFF_W-ADC_W){1'b0}}, adc_b})
                  - $signed({{(DIFF_W-OUT_W){offset[OUT_W-1]}}, offset});
  assign sum = {1'b0, adc_a} + {1'b0, adc_b};
  assign low = (sum < min_sum);

`ifdef FOCUS_DEGLITCH_EN
  logic signed [DIFF_W-1:0] hist1, hist2, med_b, med_c;
  logic                     primed;

  // Unprimed history behaves as if both slots already held the current diff.
  assign med_b = primed ? hist1 : diff_raw;
  assign med_c = primed ? hist2 : diff_raw;

  focus_median3 u_med (
    .a (diff_raw),
    .b (med_b),
    .c (med_c),
    .m (diff_f)
  );

  always_ff @(posedge clk_slow or negedge reset_n) begin
    if (!reset_n) begin
      hist1  <= '0;
      hist2  <= '0;
      primed <= 1'b0;
    end else if (enter_lost) begin
      primed <= 1'b0;
    end else if (do_acc) begin
      hist1  <= diff_raw;
      hist2  <= primed ? hist1 : diff_raw;
      primed <= 1'b1;
    end
  end
`else
  assign diff_f = diff_raw;
`endif

  assign acc_next = acc + ACC_W'(diff_f);
  assign avg      = acc_next >>> LOG2_AVG;
  assign clip_hi  = (avg > LIM_HI);
  assign clip_lo  = (avg < LIM_LO);
  assign is_last  = (cnt == CNT_LAST);

  // LOST entry wins over a coincident average completion.
  assign enter_lost = adc_valid && (state == ACCUM) && low && (lowcnt == LC_LAST);
  // In LOST only a good pair is taken; acc/cnt are already zero there, so it
  // simply becomes sample 1 of a fresh group.
  assign do_acc = adc_valid && !enter_lost && ((state == ACCUM) || !low);

  assign signal_lost = (state == LOST);

  always_ff @(posedge clk_slow or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ACCUM;
      acc          <= '0;
      cnt          <= '0;
      lowcnt       <= '0;
      focus_signal <= '0;
      focus_valid  <= 1'b0;
      sat          <= 1'b0;
    end else begin
      focus_valid <= 1'b0;
      if (enter_lost) begin
        state        <= LOST;
        acc          <= '0;
        cnt          <= '0;
        lowcnt       <= '0;
        focus_signal <= '0;
        sat          <= 1'b0;
        focus_valid  <= 1'b1;
      end else if (do_acc) begin
        state  <= ACCUM;
        lowcnt <= low ? lowcnt + 1'b1 : '0;
        if (is_last) begin
          acc          <= '0;
          cnt          <= '0;
          focus_signal <= clip_hi ? OUT_W'(SAT_MAX)
                        : clip_lo ? OUT_W'(SAT_MIN)
                        : avg[OUT_W-1:0];
          sat          <= clip_hi | clip_lo;
          focus_valid  <= 1'b1;
        end else begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_focus_error_frontend.sv
// tb_focus_error_frontend: directed bench for focus_error_frontend with the
// default parameters (12-bit ADC, 8-sample average, 4 low pairs to LOST).
// Expected outputs are queued as the group-closing pair is driven and
// checked by a monitor on every focus_valid pulse.
module tb_focus_error_frontend;
  logic               clk_slow = 1'b0;
  logic               reset_n  = 1'b0;
  logic [11:0]        adc_a    = '0;
  logic [11:0]        adc_b    = '0;
  logic               adc_valid = 1'b0;
  logic signed [15:0] offset   = '0;
  logic [12:0]        min_sum  = 13'd100;
  logic signed [15:0] focus_signal;
  logic               focus_valid;
  logic               signal_lost;
  logic               sat;

  typedef struct {
    int sig;
    int sat;
    int lost;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  focus_error_frontend #(.ADC_W(12), .LOG2_AVG(3), .LOST_CNT(4)) dut (
    .clk_slow     (clk_slow),
    .reset_n      (reset_n),
    .adc_a        (adc_a),
    .adc_b        (adc_b),
    .adc_valid    (adc_valid),
    .offset       (offset),
    .min_sum      (min_sum),
    .focus_signal (focus_signal),
    .focus_valid  (focus_valid),
    .signal_lost  (signal_lost),
    .sat          (sat)
  );

  always #5 clk_slow = ~clk_slow;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int s, input int st, input int lo);
    exp_t e;
    e.sig = s; e.sat = st; e.lost = lo;
    sb.push_back(e);
  endtask

  // One accepted pair per call; back-to-back calls give consecutive valids.
  task automatic send(input int a, input int b, input int off);
    adc_a = 12'(a); adc_b = 12'(b); offset = 16'(off); adc_valid = 1'b1;
    @(posedge clk_slow); #1;
    adc_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_slow); #1; end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #3;
    chk("rst_signal", focus_signal, 0);
    chk("rst_valid",  focus_valid,  0);
    chk("rst_lost",   signal_lost,  0);
    chk("rst_sat",    sat,          0);
    @(negedge clk_slow);
    reset_n = 1'b1;
    @(posedge clk_slow); #1;
  endtask

  always @(negedge clk_slow) begin
    if (reset_n === 1'b1 && focus_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("pulse_expected", 0, 1);
      end else begin
        mon_e = sb.pop_front();
        chk("out_signal", focus_signal, mon_e.sig);
        chk("out_sat",    sat,          mon_e.sat);
        chk("out_lost",   signal_lost,  mon_e.lost);
      end
    end
  end

  initial begin
    idle(2);
    do_reset();

    // Basic average: diff 1000.
    repeat (7) send(2000, 1000, 0);
    push(1000, 0, 0);
    send(2000, 1000, 0);
    idle(2);

    // Interleaved low pairs never reach the LOST count.
    repeat (3) send(10, 10, 0);
    send(2000, 1000, 0);
    repeat (3) send(10, 10, 0);
    push(250, 0, 0);
    send(1100, 100, 0);
    idle(2);
    chk("lowcnt_clear_lost", signal_lost, 0);

    // Offset sign, then floor rounding of -1.5.
    repeat (7) send(1000, 1000, 1500);
    push(-1500, 0, 0);
    send(1000, 1000, 1500);
    repeat (3) begin send(1000, 1000, 1); send(1000, 1000, 2); end
    send(1000, 1000, 1);
    push(-2, 0, 0);
    send(1000, 1000, 2);
    idle(2);

    // Positive clip, sat holds, clears on next output, negative clip.
    repeat (7) send(4095, 0, -32768);
    push(32767, 1, 0);
    send(4095, 0, -32768);
    idle(4);
    chk("sat_hold", sat, 1);
    chk("sig_hold", focus_signal, 32767);
    repeat (7) send(1000, 1000, 0);
    push(0, 0, 0);
    send(1000, 1000, 0);
    repeat (7) send(0, 4095, 32767);
    push(-32768, 1, 0);
    send(0, 4095, 32767);
    idle(2);

    // Signal lost and recovery.
    repeat (3) send(10, 10, 0);
    chk("lost_before", signal_lost, 0);
    push(0, 0, 1);
    send(10, 10, 0);
    chk("lost_rise", signal_lost, 1);
    repeat (5) send(10, 10, 0);
    idle(3);
    chk("lost_stay", signal_lost, 1);
    send(600, 500, 0);
    chk("lost_fall", signal_lost, 0);
    repeat (6) send(600, 500, 0);
    push(100, 0, 0);
    send(600, 500, 0);
    idle(2);

    // LOST on the group-completing pair suppresses the average.
    repeat (4) send(2000, 1000, 0);
    push(0, 0, 1);
    repeat (4) send(10, 10, 0);
    idle(2);
    chk("prio_lost", signal_lost, 1);
    repeat (7) send(1200, 1000, 0);
    push(200, 0, 0);
    send(1200, 1000, 0);
    idle(2);
    chk("pre_reset_sig", focus_signal, 200);

    // Reset mid-average discards the partial sum.
    repeat (5) send(2000, 1000, 0);
    do_reset();
    repeat (7) send(1200, 1000, 0);
    idle(3);
    push(200, 0, 0);
    send(1200, 1000, 0);
    idle(2);

    // Gapped valids give the same result as back-to-back ones.
    for (int i = 0; i < 7; i++) begin
      send(700, 1000, 0);
      idle(i % 3 + 1);
    end
    push(-300, 0, 0);
    send(700, 1000, 0);
    idle(2);

    // Single spike in a group of 100s.
    do_reset();
    send(1100, 1000, 0);
    send(1100, 1000, 0);
    send(4000, 0, 0);
    repeat (4) send(1100, 1000, 0);
`ifdef FOCUS_DEGLITCH_EN
    push(100, 0, 0);
`else
    push(587, 0, 0);
`endif
    send(1100, 1000, 0);
    idle(5);

    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
